mem_bus_master: RTL and testbench
=================================

// Module: mem_bus_master
// PURPOSE
//  Initiator side of the 19-bit synchronous memory interface. Accepts single-beat read/write
//  requests on a valid/ready command port and sequences the memory's we/addr/mem_in pins.
//  Turns around the shared bidirectional data bus, captures read data one cycle after the
//  address and returns it on a valid/ready response port. Sits between core logic and the 1K x 19 store.
// PARAMETERS
//  ADDR_W   19    request/memory address width
//  DATA_W   19    data width (mem_in, data bus, req/rsp data)
//  DEPTH    1024  implemented words; addresses >= DEPTH are rejected with rsp_err
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  req_valid   in   1       command valid
//  req_ready   out  1       command accepted when valid&&ready
//  req_write   in   1       1=write, 0=read
//  req_addr    in   ADDR_W  word address
//  req_wdata   in   DATA_W  write data
//  rsp_valid   out  1       response valid (held until rsp_ready)
//  rsp_ready   in   1       response consumed
//  rsp_write   out  1       echo of req_write for this response
//  rsp_err     out  1       1 = address out of range, no memory access made
//  rsp_rdata   out  DATA_W  read data (0 for writes / errors)
//  mem_we      out  1       memory write enable
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  to memory mem_in
//  mem_data    inout DATA_W shared bus; memory drives it whenever mem_we=0
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state IDLE; req_ready=0 during rst, 1 the cycle after;
//    rsp_valid/rsp_write/rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, bus hi-Z.
//    Reset mid-operation aborts immediately; pending response is dropped, no write is committed
//    unless mem_we was already high on that same edge.
//  - All outputs registered. One outstanding request; req_ready=1 only in IDLE.
//  - FSM: IDLE -> (accept, write, addr ok) WR -> RESP
//         IDLE -> (accept, read, addr ok)  RD_ADDR -> RD_WAIT -> RESP
//         IDLE -> (accept, addr >= DEPTH)  RESP with rsp_err=1, no mem_we pulse
//         RESP -> IDLE when rsp_ready (rsp_valid, rsp_* stable while waiting).
//  - WR: mem_we=1 exactly one cycle, mem_addr/mem_wdata = latched request; bus driven with
//    wdata only while mem_we=1, hi-Z every other cycle (mem_we and bus enable from same flop).
//  - RD_ADDR: mem_we=0, mem_addr=A (memory registers data at end of cycle).
//  - RD_WAIT: sample mem_data at end of cycle into rsp_rdata.
//  - Latency, accept edge = E0: write rsp_valid high in cycle after E0+1 (mem_we in E0..E0+1);
//    read mem_addr in E0..E0+1, capture at E0+2, rsp_valid from E0+2; error rsp_valid from E0+1.
//  - Address compare is unsigned on full ADDR_W; DEPTH-1 is valid, DEPTH is error.
//  - rsp_ready held high: back-to-back throughput = 1 write / 3 cycles, 1 read / 4 cycles.
//  - mem_addr holds its last value when idle; mem_we never high outside WR.
// STRUCTURE
//  - mem_if_pkg (shared include): ADDR_W/DATA_W/DEPTH defaults, FSM state encodings
//    (IDLE, WR, RD_ADDR, RD_WAIT, RESP), reused by the memory model and testbench.
//  - One sub-module: mem_bus_drv -- tristate driver/sampler for mem_data (oe, dout, din).
// TESTING
//  1. rst high 2 cycles mid-read -> all outputs at reset values, no rsp_valid, req_ready=1 after.
//  2. write A=0x005 D=0x7ABCD, then read A=0x005 -> mem_we one cycle, rsp_rdata=0x7ABCD, err=0.
//  3. write A=0x3FF (DEPTH-1) D=0x00001, read back -> 0x00001; access A=0x400 -> rsp_err=1,
//     no mem_we pulse, rsp_rdata=0.
//  4. rsp_ready low 5 cycles after read -> rsp_valid/rdata stable, req_ready=0 throughout.
//  5. streaming W,R,W,R with req_valid and rsp_ready always high -> 3/4-cycle spacing,
//     bus never driven by master when mem_we=0 (no X on mem_data).
//  6. read never-written A=0x010 after writes elsewhere -> data from model init, neighbours untouched.

Source files
------------

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, depth and FSM encodings for the 19-bit memory interface
package mem_if_pkg;

  localparam int MEM_ADDR_W = 19;
  localparam int MEM_DATA_W = 19;
  localparam int MEM_DEPTH  = 1024;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_bus_drv.sv
// rtl/mem_bus_drv.sv - tristate driver and sampler for the shared memory data bus
module mem_bus_drv #(
  parameter int DATA_W = 19
) (
  input  logic              oe,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] bus
);

  assign bus = oe ? dout : {DATA_W{1'bz}};
  assign din = bus;

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - single-outstanding read/write initiator for the 1K x 19 synchronous store
module mem_bus_master
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  inout  wire  [DATA_W-1:0] mem_data
);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              addr_ok;
  logic [DATA_W-1:0] bus_din;

  logic              req_ready_d;
  logic              rsp_valid_d;
  logic              rsp_write_d;
  logic              rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  assign accept  = req_valid && req_ready;
  assign addr_ok = (req_addr < ADDR_W'(DEPTH));

  // mem_we doubles as the bus output enable so the bus is driven only during the write pulse
  mem_bus_drv #(.DATA_W(DATA_W)) u_drv (
    .oe   (mem_we),
    .dout (mem_wdata),
    .din  (bus_din),
    .bus  (mem_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!addr_ok) begin
            next_state = RESP;
          end else if (req_write) begin
            next_state = WR;
          end else begin
            next_state = RD_ADDR;
          end
        end
      end
      WR:      next_state = RESP;
      RD_ADDR: next_state = RD_WAIT;
      RD_WAIT: next_state = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = (next_state == IDLE);
    mem_we_d    = (next_state == WR);
    // a rejected request spends one cycle in RESP before rsp_valid rises
    rsp_valid_d = (next_state == RESP) && (state != IDLE);
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rsp_write_d = rsp_write;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    if (accept) begin
      rsp_write_d = req_write;
      rsp_err_d   = !addr_ok;
      rsp_rdata_d = '0;
      if (addr_ok) begin
        mem_addr_d = req_addr;
        if (req_write) begin
          mem_wdata_d = req_wdata;
        end
      end
    end
    if (state == RD_WAIT) begin
      rsp_rdata_d = bus_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_write <= rsp_write_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - self-checking bench for mem_bus_master with a synchronous memory model
module tb_mem_bus_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [18:0] req_addr;
  logic [18:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic        rsp_err;
  logic [18:0] rsp_rdata;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [18:0] mem_wdata;
  wire  [18:0] mem_data;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  int cyc = 0;
  logic bus_chk = 1'b0;

  logic [18:0] mem_model [1024];
  logic [18:0] ref_mem [1024];
  logic [18:0] rd_q;

  mem_bus_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_data  (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] init_val(input int i);
    logic [31:0] t;
    t = (i * 32'h9E37) ^ 32'h5A5A5;
    return t[18:0];
  endfunction

  // synchronous memory: registers read data every cycle, drives the bus whenever mem_we=0
  initial for (int i = 0; i < 1024; i++) mem_model[i] = init_val(i);
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr[9:0]] <= mem_wdata;
    rd_q <= mem_model[mem_addr[9:0]];
  end
  assign mem_data = mem_we ? 19'bz : rd_q;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_chk) chk("bus_value", 32'(mem_data), mem_we ? 32'(mem_wdata) : 32'(rd_q));
  end

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_write", 32'(rsp_write), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
  endtask

  task automatic run_txn(input logic w, input logic [18:0] a, input logic [18:0] d, input int stall,
                         input logic exp_err, input logic [18:0] exp_rd);
    int n;
    int we0;
    int exp_lat;
    logic [18:0] hold;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    we0 = we_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 12);
    exp_lat = (exp_err || w) ? 2 : 3;
    chk("rsp_latency", 32'(n), 32'(exp_lat));
    if (!rsp_valid) return;
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_write", 32'(rsp_write), 32'(w));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    hold = rsp_rdata;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 1);
      chk("stall_rsp_rdata", 32'(rsp_rdata), 32'(hold));
      chk("stall_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_req_ready", 32'(req_ready), 1);
    chk("we_pulses", 32'(we_cnt - we0), (w && !exp_err) ? 1 : 0);
  endtask

  task automatic model_txn(input logic w, input logic [18:0] a, input logic [18:0] d, input int stall);
    logic err;
    logic [18:0] exp_rd;
    err = (a >= 19'd1024);
    exp_rd = (w || err) ? 19'd0 : ref_mem[a[9:0]];
    run_txn(w, a, d, stall, err, exp_rd);
    if (w && !err) ref_mem[a[9:0]] = d;
  endtask

  typedef struct {
    logic        w;
    logic [18:0] a;
    logic [18:0] d;
    int          stall;
    logic        err;
    logic [18:0] rd;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        sw [4];
    logic [18:0] sa [4];
    logic [18:0] sd [4];
    int          acc [4];
    logic [18:0] rrd [4];
    logic        rwr [4];
    int          k;
    int          r;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    tbl[0]  = '{1'b1, 19'h005,   19'h7ABCD, 0, 1'b0, 19'h0};
    tbl[1]  = '{1'b0, 19'h005,   19'h0,     0, 1'b0, 19'h7ABCD};
    tbl[2]  = '{1'b1, 19'h3FF,   19'h00001, 0, 1'b0, 19'h0};
    tbl[3]  = '{1'b0, 19'h3FF,   19'h0,     0, 1'b0, 19'h00001};
    tbl[4]  = '{1'b1, 19'h400,   19'h12345, 0, 1'b1, 19'h0};
    tbl[5]  = '{1'b0, 19'h400,   19'h0,     0, 1'b1, 19'h0};
    tbl[6]  = '{1'b0, 19'h005,   19'h0,     5, 1'b0, 19'h7ABCD};
    tbl[7]  = '{1'b1, 19'h011,   19'h55555, 0, 1'b0, 19'h0};
    tbl[8]  = '{1'b1, 19'h00F,   19'h2AAAA, 2, 1'b0, 19'h0};
    tbl[9]  = '{1'b0, 19'h010,   19'h0,     0, 1'b0, init_val(16)};
    tbl[10] = '{1'b0, 19'h011,   19'h0,     1, 1'b0, 19'h55555};
    tbl[11] = '{1'b0, 19'h00F,   19'h0,     0, 1'b0, 19'h2AAAA};
    tbl[12] = '{1'b0, 19'h7FFFF, 19'h0,     0, 1'b1, 19'h0};
    tbl[13] = '{1'b0, 19'h006,   19'h0,     0, 1'b0, init_val(6)};
    tbl[14] = '{1'b0, 19'h3FE,   19'h0,     0, 1'b0, init_val(1022)};
    tbl[15] = '{1'b1, 19'h7FFFF, 19'h3C3C3, 3, 1'b1, 19'h0};
    tbl[16] = '{1'b0, 19'h000,   19'h0,     0, 1'b0, init_val(0)};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(req_ready), 1);
    bus_chk = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].stall, tbl[i].err, tbl[i].rd);
      if (tbl[i].w && !tbl[i].err) ref_mem[tbl[i].a[9:0]] = tbl[i].d;
    end

    // reset while a read is in flight
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 19'h123;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 0);
    end

    // streaming W,R,W,R with req_valid and rsp_ready held high
    sw[0] = 1'b1; sa[0] = 19'h020; sd[0] = 19'h1F0F0;
    sw[1] = 1'b0; sa[1] = 19'h020; sd[1] = 19'h0;
    sw[2] = 1'b1; sa[2] = 19'h021; sd[2] = 19'h60A0B;
    sw[3] = 1'b0; sa[3] = 19'h021; sd[3] = 19'h0;
    for (int i = 0; i < 4; i++) begin
      acc[i] = 0; rrd[i] = '0; rwr[i] = 1'b0;
    end
    k = 0; r = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = sw[0]; req_addr = sa[0]; req_wdata = sd[0];
    for (int c = 0; c < 60 && r < 4; c++) begin
      if (rsp_valid) begin
        rrd[r] = rsp_rdata; rwr[r] = rsp_write; r++;
      end
      if (req_valid && req_ready) begin
        acc[k] = cyc; k++;
        @(posedge clk);
        #1;
        if (k < 4) begin
          req_write = sw[k]; req_addr = sa[k]; req_wdata = sd[k];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("stream_rsp_count", 32'(r), 4);
    for (int i = 1; i < 4; i++) chk("stream_spacing", 32'(acc[i] - acc[i-1]), sw[i-1] ? 3 : 4);
    for (int i = 0; i < 4; i++) begin
      chk("stream_rsp_write", 32'(rwr[i]), 32'(sw[i]));
      chk("stream_rsp_rdata", 32'(rrd[i]), sw[i] ? 0 : 32'(sd[i-1]));
    end
    ref_mem[32] = sd[0];
    ref_mem[33] = sd[2];

    // randomized traffic against the reference array
    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [18:0] a;
      int          sel;
      w   = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 9);
      if (sel < 5)      a = 19'($urandom_range(0, 31));
      else if (sel < 8) a = 19'($urandom_range(0, 1023));
      else              a = 19'($urandom_range(1024, 19'h7FFFF));
      model_txn(w, a, 19'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
